// File: rtl/ahb_master_port_if.sv
// Bundles the command/response handshake and AHB master-side bus signals of one
// ahb_master_port. The master modport is the port's view; slave is the environment's.
interface ahb_master_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              hreq;
  logic              hgrant;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, hgrant, hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, hreq, sel, haddr, hwrite,
           htrans, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata, hgrant, hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, hreq, sel, haddr, hwrite,
           htrans, hwdata
  );
endinterface

// File: rtl/ahb_master_port.sv
// Bus-requesting AHB master endpoint: latches one command, requests the bus, runs a single
// transfer with bounded retry on ERROR and a grant timeout, then strobes one response.
// All outputs are registers updated alongside the state, so no input reaches an output
// combinationally.
module ahb_master_port #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned GRANT_TIMEOUT = 16
) (
  input logic               hclk,
  input logic               hreset,
  ahb_master_port_if.master bus
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TmoW   = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  // Value of the timeout counter on the last grant-less REQ cycle before aborting.
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(GRANT_TIMEOUT - 1);
  localparam logic [1:0]        TrIdle   = 2'b00;
  localparam logic [1:0]        TrNonseq = 2'b10;

  typedef enum logic [2:0] {StIdle, StReq, StAddr, StData, StResp} state_e;

  state_e             r_state;
  logic               r_write;
  logic [1:0]         r_sel;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [RetryW-1:0]  r_retry;
  logic [TmoW-1:0]    r_tmo;

  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_rsp_timeout;
  logic               r_hreq;
  logic [1:0]         r_hsel;
  logic [ADDR_W-1:0]  r_haddr;
  logic               r_hwrite;
  logic [1:0]         r_htrans;
  logic [DATA_W-1:0]  r_hwdata;

  // State, command latch, counters and registered outputs for the destination state.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state       <= StIdle;
      r_write       <= 1'b0;
      r_sel         <= 2'b00;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_retry       <= '0;
      r_tmo         <= '0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_hreq        <= 1'b0;
      r_hsel        <= 2'b00;
      r_haddr       <= '0;
      r_hwrite      <= 1'b0;
      r_htrans      <= TrIdle;
      r_hwdata      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_retry <= '0;
          r_tmo   <= '0;
          if (bus.cmd_valid) begin
            r_write     <= bus.cmd_write;
            r_sel       <= bus.cmd_sel;
            r_addr      <= bus.cmd_addr;
            r_wdata     <= bus.cmd_wdata;
            r_state     <= StReq;
            r_cmd_ready <= 1'b0;
            r_hreq      <= 1'b1;
            r_hsel      <= bus.cmd_sel;
          end
        end
        StReq: begin
          if (bus.hgrant) begin
            r_state  <= StAddr;
            r_htrans <= TrNonseq;
            r_haddr  <= r_addr;
            r_hwrite <= r_write;
          end else if (GRANT_TIMEOUT != 0) begin
            r_tmo <= r_tmo + 1'b1;
            if (r_tmo == TmoLast) begin
              r_state       <= StResp;
              r_hreq        <= 1'b0;
              r_hsel        <= 2'b00;
              r_rsp_valid   <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_rsp_err     <= 1'b0;
              r_rsp_rdata   <= '0;
            end
          end
        end
        StAddr: begin
          if (bus.hready) begin
            r_state  <= StData;
            r_hreq   <= 1'b0;
            r_htrans <= TrIdle;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hwdata <= r_write ? r_wdata : '0;
          end
        end
        StData: begin
          if (bus.hready) begin
            r_hwdata <= '0;
            if (!bus.hresp) begin
              r_state     <= StResp;
              r_hsel      <= 2'b00;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= r_write ? '0 : bus.hrdata;
            end else if (r_retry < RetryMax) begin
              r_retry <= r_retry + 1'b1;
              r_tmo   <= '0;
              r_state <= StReq;
              r_hreq  <= 1'b1;
            end else begin
              r_state     <= StResp;
              r_hsel      <= 2'b00;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end
          end
        end
        StResp: begin
          r_state       <= StIdle;
          r_cmd_ready   <= 1'b1;
          r_rsp_valid   <= 1'b0;
          r_rsp_err     <= 1'b0;
          r_rsp_timeout <= 1'b0;
          r_rsp_rdata   <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.hreq        = r_hreq;
  assign bus.sel         = r_hsel;
  assign bus.haddr       = r_haddr;
  assign bus.hwrite      = r_hwrite;
  assign bus.htrans      = r_htrans;
  assign bus.hwdata      = r_hwdata;

endmodule

// File: tb/tb_ahb_master_port.sv
// Bench for ahb_master_port: a behavioural arbiter/slave answers each transfer, and the
// expected response, latency and bus activity are derived from the command parameters.
module tb_ahb_master_port;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MaxRetry = 2;
  localparam int unsigned GrantTmo = 16;

  logic hclk;
  logic hreset;
  int   n_checks;
  int   n_fail;

  ahb_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_master_port #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MaxRetry), .GRANT_TIMEOUT(GrantTmo)
  ) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Observations collected by run_txn.
  bit          ob_got;
  int          ob_cyc;
  logic [31:0] ob_rdata;
  logic        ob_err;
  logic        ob_tmo;
  int          ob_nonseq;
  int          ob_rises;
  int          ob_bad_addr;
  int          ob_bad_data;
  int          ob_both;

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_sel   = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.hgrant    = 1'b0;
    bus.hrdata    = '0;
    bus.hready    = 1'b0;
    bus.hresp     = 1'b0;
  endtask

  // Issues one command and plays arbiter + slave: grant after gdelay REQ cycles, wst data
  // wait states, ERROR on the first nerr data phases. poke pulses a bogus command while busy.
  task automatic run_txn(input logic wr, input logic [1:0] sl, input logic [31:0] ad,
                         input logic [31:0] wd, input int gdelay, input int wst,
                         input int nerr, input logic [31:0] hr, input bit poke);
    int  reqc;
    int  dw;
    int  att;
    bit  prev_hreq;
    ob_got = 0; ob_cyc = 0; ob_rdata = '0; ob_err = 1'b0; ob_tmo = 1'b0;
    ob_nonseq = 0; ob_rises = 0; ob_bad_addr = 0; ob_bad_data = 0; ob_both = 0;
    reqc = 0; dw = 0; att = 0; prev_hreq = 1'b0;
    @(negedge hclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_sel = sl;
    bus.cmd_addr = ad; bus.cmd_wdata = wd;
    @(negedge hclk);
    bus.cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      bus.hgrant = 1'b0; bus.hready = 1'b0; bus.hresp = 1'b0; bus.hrdata = $urandom;
      if (poke && cyc <= 3) begin
        bus.cmd_valid = 1'b1; bus.cmd_write = ~wr; bus.cmd_sel = ~sl;
        bus.cmd_addr = ~ad; bus.cmd_wdata = ~wd;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      if (bus.rsp_err && bus.rsp_timeout) ob_both++;
      if (bus.rsp_valid) begin
        ob_got = 1; ob_cyc = cyc; ob_rdata = bus.rsp_rdata;
        ob_err = bus.rsp_err; ob_tmo = bus.rsp_timeout;
        break;
      end else if (bus.hreq && bus.htrans == 2'b00) begin
        if (!prev_hreq) ob_rises++;
        if (bus.sel !== sl) ob_bad_addr++;
        if (reqc >= gdelay) bus.hgrant = 1'b1;
        reqc++;
      end else if (bus.htrans == 2'b10) begin
        ob_nonseq++;
        if (bus.haddr !== ad || bus.hwrite !== wr || bus.sel !== sl || !bus.hreq)
          ob_bad_addr++;
        bus.hready = 1'b1;
        reqc = 0; dw = 0;
      end else if (!bus.cmd_ready) begin
        if (bus.hwdata !== (wr ? wd : 32'h0) || bus.sel !== sl || bus.haddr !== '0)
          ob_bad_data++;
        if (dw >= wst) begin
          bus.hready = 1'b1;
          bus.hresp  = (att < nerr);
          if (att >= nerr) bus.hrdata = hr;
          att++;
        end
        dw++;
      end
      prev_hreq = bus.hreq;
      @(negedge hclk);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.hreq !== 1'b0 || bus.htrans !== 2'b00 ||
        bus.sel !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.haddr !== '0 ||
        bus.hwdata !== '0 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b hreq=%b htrans=%b sel=%b rsp=%b want ready=1 rest 0",
               bus.cmd_ready, bus.hreq, bus.htrans, bus.sel, bus.rsp_valid);
    end
  endtask

  task automatic test_write_basic();
    run_txn(1'b1, 2'b01, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 1'b0);
    n_checks++;
    if (!ob_got || ob_cyc != 4) begin
      n_fail++; $display("FAIL write_latency: got=%0d cyc=%0d want cyc=4", ob_got, ob_cyc);
    end
    n_checks++;
    if (ob_err !== 1'b0 || ob_tmo !== 1'b0 || ob_rdata !== 32'h0) begin
      n_fail++; $display("FAIL write_rsp: err=%b tmo=%b rdata=%h want 0 0 0",
                         ob_err, ob_tmo, ob_rdata);
    end
    n_checks++;
    if (ob_nonseq != 1 || ob_bad_addr != 0 || ob_bad_data != 0) begin
      n_fail++; $display("FAIL write_bus: nonseq=%0d bad_addr=%0d bad_data=%0d want 1 0 0",
                         ob_nonseq, ob_bad_addr, ob_bad_data);
    end
    @(negedge hclk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_ready_back: ready=%b rsp=%b want 1 0",
                         bus.cmd_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_read_waits();
    run_txn(1'b0, 2'b10, 32'h20, 32'hFFFF0000, 0, 3, 0, 32'h1234, 1'b0);
    n_checks++;
    if (!ob_got || ob_cyc != 7 || ob_rdata !== 32'h1234) begin
      n_fail++; $display("FAIL read_waits: got=%0d cyc=%0d rdata=%h want cyc=7 rdata=1234",
                         ob_got, ob_cyc, ob_rdata);
    end
    n_checks++;
    if (ob_bad_addr != 0 || ob_bad_data != 0) begin
      n_fail++; $display("FAIL read_stable: bad_addr=%0d bad_data=%0d want 0 0",
                         ob_bad_addr, ob_bad_data);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 2'b11, 32'h40, 32'h5, 1000, 0, 0, 32'h0, 1'b0);
    n_checks++;
    if (!ob_got || ob_cyc != 1 + GrantTmo || ob_tmo !== 1'b1 || ob_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_rsp: got=%0d cyc=%0d tmo=%b err=%b want cyc=%0d 1 0",
                         ob_got, ob_cyc, ob_tmo, ob_err, 1 + GrantTmo);
    end
    n_checks++;
    if (ob_nonseq != 0) begin
      n_fail++; $display("FAIL timeout_htrans: nonseq=%0d want 0", ob_nonseq);
    end
    // One cycle short of the limit: the late grant must still win.
    run_txn(1'b0, 2'b01, 32'h44, 32'h0, GrantTmo - 1, 0, 0, 32'hA5A5, 1'b0);
    n_checks++;
    if (!ob_got || ob_tmo !== 1'b0 || ob_rdata !== 32'hA5A5 || ob_cyc != GrantTmo + 3) begin
      n_fail++; $display("FAIL late_grant: got=%0d tmo=%b rdata=%h cyc=%0d want 0 a5a5 %0d",
                         ob_got, ob_tmo, ob_rdata, ob_cyc, GrantTmo + 3);
    end
  endtask

  task automatic test_retry_ok();
    run_txn(1'b0, 2'b01, 32'h80, 32'h0, 0, 0, 2, 32'hCAFE, 1'b0);
    n_checks++;
    if (ob_rises != 3 || ob_nonseq != 3) begin
      n_fail++; $display("FAIL retry_count: rises=%0d nonseq=%0d want 3 3", ob_rises, ob_nonseq);
    end
    n_checks++;
    if (!ob_got || ob_err !== 1'b0 || ob_rdata !== 32'hCAFE || ob_cyc != 10) begin
      n_fail++; $display("FAIL retry_rsp: got=%0d err=%b rdata=%h cyc=%0d want 0 cafe 10",
                         ob_got, ob_err, ob_rdata, ob_cyc);
    end
  endtask

  task automatic test_retry_fail();
    run_txn(1'b0, 2'b10, 32'h84, 32'h0, 1, 1, 3, 32'hBEEF, 1'b0);
    n_checks++;
    if (!ob_got || ob_err !== 1'b1 || ob_tmo !== 1'b0 || ob_rdata !== 32'h0) begin
      n_fail++; $display("FAIL retry_fail: got=%0d err=%b tmo=%b rdata=%h want 1 0 0",
                         ob_got, ob_err, ob_tmo, ob_rdata);
    end
    n_checks++;
    if (ob_nonseq != 3) begin
      n_fail++; $display("FAIL retry_fail_attempts: nonseq=%0d want 3", ob_nonseq);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    saw_rsp = 0;
    @(negedge hclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_sel = 2'b11;
    bus.cmd_addr = 32'h99; bus.cmd_wdata = 32'h77;
    @(negedge hclk);
    bus.cmd_valid = 1'b0; bus.hgrant = 1'b1;
    @(negedge hclk);
    bus.hgrant = 1'b0; bus.hready = 1'b1;
    @(negedge hclk);
    bus.hready = 1'b0;
    @(negedge hclk);
    hreset = 1'b1;
    #1;
    n_checks++;
    if (bus.hreq !== 1'b0 || bus.htrans !== 2'b00 || bus.sel !== 2'b00 ||
        bus.hwdata !== '0) begin
      n_fail++; $display("FAIL reset_mid: hreq=%b htrans=%b sel=%b hwdata=%h want all 0",
                         bus.hreq, bus.htrans, bus.sel, bus.hwdata);
    end
    @(negedge hclk);
    hreset = 1'b0;
    bus.hready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge hclk);
      if (bus.rsp_valid) saw_rsp = 1;
    end
    bus.hready = 1'b0;
    n_checks++;
    if (saw_rsp || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_after: rsp_seen=%0d ready=%b want 0 1",
                         saw_rsp, bus.cmd_ready);
    end
  endtask

  task automatic test_busy_ignore();
    run_txn(1'b1, 2'b01, 32'h123, 32'h456, 0, 0, 0, 32'h0, 1'b1);
    n_checks++;
    if (!ob_got || ob_cyc != 4 || ob_bad_addr != 0 || ob_bad_data != 0) begin
      n_fail++; $display("FAIL busy_ignore: got=%0d cyc=%0d bad_addr=%0d bad_data=%0d",
                         ob_got, ob_cyc, ob_bad_addr, ob_bad_data);
    end
    @(negedge hclk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.hreq !== 1'b0) begin
      n_fail++; $display("FAIL busy_not_queued: ready=%b hreq=%b want 1 0",
                         bus.cmd_ready, bus.hreq);
    end
  endtask

  task automatic test_random();
    int gsel;
    int gd, ws, ne, attempts, exp_cyc;
    logic wr;
    logic [1:0] sl;
    logic [31:0] ad, wd, hr, exp_rd;
    bit exp_tmo, exp_err;
    for (int t = 0; t < 30; t++) begin
      gsel = $urandom_range(0, 9);
      gd   = (gsel == 8) ? int'(GrantTmo) - 1 : (gsel == 9) ? int'(GrantTmo) : gsel % 4;
      ws   = $urandom_range(0, 3);
      ne   = $urandom_range(0, 3);
      wr   = 1'($urandom);
      sl   = 2'($urandom);
      ad   = $urandom; wd = $urandom; hr = $urandom;
      exp_tmo  = (gd >= int'(GrantTmo));
      exp_err  = !exp_tmo && (ne > int'(MaxRetry));
      attempts = exp_tmo ? 0 : ((ne < int'(MaxRetry)) ? ne : int'(MaxRetry)) + 1;
      exp_cyc  = exp_tmo ? 1 + int'(GrantTmo) : 1 + attempts * (gd + ws + 3);
      exp_rd   = (!wr && !exp_tmo && !exp_err) ? hr : 32'h0;
      run_txn(wr, sl, ad, wd, gd, ws, ne, hr, 1'b0);
      n_checks++;
      if (!ob_got || ob_cyc != exp_cyc || ob_err !== exp_err || ob_tmo !== exp_tmo ||
          ob_rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got=%0d cyc=%0d err=%b tmo=%b rd=%h want %0d %b %b %h",
                 t, ob_got, ob_cyc, ob_err, ob_tmo, ob_rdata, exp_cyc, exp_err, exp_tmo,
                 exp_rd);
      end
      n_checks++;
      if (ob_nonseq != attempts || ob_rises != (exp_tmo ? 1 : attempts) ||
          ob_bad_addr != 0 || ob_bad_data != 0 || ob_both != 0) begin
        n_fail++;
        $display("FAIL rand_bus[%0d]: nonseq=%0d rises=%0d bad=%0d/%0d both=%0d want %0d",
                 t, ob_nonseq, ob_rises, ob_bad_addr, ob_bad_data, ob_both, attempts);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hreset   = 1'b1;
    idle_inputs();
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    @(negedge hclk);
    test_reset();
    test_write_basic();
    test_read_waits();
    test_timeout();
    test_retry_ok();
    test_retry_fail();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_master_port.md
Name: ahb_master_port

Overview:
- Bus-requesting master endpoint for the two-master AHB fabric; one instance per master.
- Accepts single read/write commands from local logic and raises hreq to the arbiter. On hgrant it runs one AHB single transfer (address phase, then data phase) to the slave given by the command's select code, then returns a response.
- Retries on slave ERROR, up to a limit. Aborts with a timeout if the grant never arrives.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_RETRY, 2, number of re-attempts after ERROR before reporting failure (0 = no retry)
GRANT_TIMEOUT, 16, cycles to wait for hgrant before aborting (0 = wait forever)

Ports:
hclk  input  1  bus clock, rising edge
hreset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request from local logic
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_sel  input  2  slave select code, driven to the arbiter sel input
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  DATA_W  read data (0 for writes and failures)
rsp_err  output  1  transfer failed with ERROR after all retries
rsp_timeout  output  1  grant never received
hreq  output  1  bus request to arbiter
hgrant  input  1  grant from arbiter
sel  output  2  slave select to arbiter
haddr  output  ADDR_W  AHB address
hwrite  output  1  AHB write
htrans  output  2  00 IDLE, 10 NONSEQ
hwdata  output  DATA_W  AHB write data
hrdata  input  DATA_W  AHB read data
hready  input  1  transfer ready from selected slave
hresp  input  1  0 OKAY, 1 ERROR

Behaviour:
- Reset: async on hreset=1; state IDLE; all outputs 0 except cmd_ready=1; latched command, retry and timeout counters cleared.
- Reset mid-operation: the transfer is abandoned and no response is issued. hreq and htrans go 0 immediately.
- Moore style: every output is a function of registered state and latched command only. There is no combinational path from any input to any output.
- States: IDLE, REQ, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - cmd_valid=1 latches cmd_* and moves to REQ.
  - Retry and timeout counters clear.
- REQ:
  - hreq=1, htrans=00, sel=latched cmd_sel.
  - hgrant sampled 1 moves to ADDR.
  - Otherwise the timeout counter increments. When it reaches GRANT_TIMEOUT (nonzero), go to RESP with rsp_timeout=1.
- ADDR:
  - hreq=1, htrans=10, haddr and hwrite from latch, sel held.
  - hready=1 moves to DATA. hready=0 holds all address-phase outputs.
- DATA:
  - hreq=0, htrans=00.
  - hwdata = latched wdata (held valid for writes, 0 for reads); sel held.
  - Waits while hready=0.
  - hready=1 and hresp=0: capture hrdata (reads only), go to RESP with OK.
  - hready=1 and hresp=1: if retry count < MAX_RETRY, increment it, clear the timeout counter and go to REQ. Otherwise go to RESP with rsp_err=1.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata, rsp_err and rsp_timeout valid.
  - Next state is IDLE; rsp_* return to 0.
- cmd_ready=0 in every state except IDLE. cmd_valid outside IDLE is ignored and not queued.
- hgrant is ignored in all states except REQ.
- rsp_err and rsp_timeout are never both 1.
- Minimum latency with zero wait states and grant on the first REQ cycle: cmd accept at cycle 0, hreq at cycle 1, NONSEQ at cycle 2, data phase at cycle 3, rsp_valid at cycle 4.
- Counter widths: the retry counter holds 0..MAX_RETRY; the timeout counter holds 0..GRANT_TIMEOUT. Neither wraps.

Test Plan:
1. Write 0xDEADBEEF to addr 0x10, sel=01, grant after 1 cycle, hready=1 -> htrans=10 with haddr=0x10 and hwrite=1 for one cycle, then hwdata=0xDEADBEEF; rsp_valid at cycle 4 with err=0, timeout=0; cmd_ready back to 1.
2. Read addr 0x20, sel=10, slave inserts 3 wait states in data phase, hrdata=0x1234 -> haddr and hwdata stable during waits; rsp_rdata=0x1234 one cycle after hready rises.
3. Hold hgrant=0 with GRANT_TIMEOUT=16 -> rsp_valid with rsp_timeout=1 after 16 REQ cycles; htrans never leaves 00.
4. Slave answers ERROR twice, then OKAY (MAX_RETRY=2) -> hreq reasserted twice, three NONSEQ cycles total; rsp_err=0.
5. Slave answers ERROR three times -> rsp_err=1 after the third attempt; rsp_rdata=0.
6. Assert hreset during a DATA-phase wait -> hreq, htrans and sel are 0 immediately; no rsp_valid; cmd_ready=1 after release. A cmd_valid pulsed during the busy cycles of a new transfer is not accepted.
